// File: rtl/clk_divider.sv
// ---------------------------------------------------------------------------
// clk_divider
//   Free-running even-ratio divider. Produces a 50 % duty-cycle square wave
//   with a half-period of MAX_COUNT+1 input cycles, so
//   f_out = f_clk / (2*(MAX_COUNT+1)).
//   The output is an ordinary register. Consumers sample it or edge-detect it;
//   it is not meant to drive a clock network.
//
// Parameters
//   COUNT_WIDTH : width of the internal cycle counter
//   MAX_COUNT   : terminal count, 0 .. 2**COUNT_WIDTH-1
//
// Ports
//   clk : system clock, rising-edge logic
//   rst : synchronous active-high reset (clears counter and output)
//   out : divided square wave, registered
// ---------------------------------------------------------------------------
module clk_divider #(
    parameter int COUNT_WIDTH = 24,
    parameter int MAX_COUNT   = 5_999_999
) (
    input  logic clk,
    input  logic rst,
    output logic out
);

    localparam longint unsigned MAX_LEGAL = (64'd1 << COUNT_WIDTH) - 64'd1;

    // Refuse to elaborate with a terminal count the counter cannot hold.
    generate
        if (MAX_COUNT < 0 || longint'(MAX_COUNT) > MAX_LEGAL) begin : g_bad_max_count
            $fatal(1, "clk_divider: MAX_COUNT out of range for COUNT_WIDTH");
        end
    endgenerate

    localparam logic [COUNT_WIDTH-1:0] TERMINAL = COUNT_WIDTH'(MAX_COUNT);

    // Declaration initialisers give a defined power-up state, so the block
    // runs correctly with no reset pulse at all.
    logic [COUNT_WIDTH-1:0] count_q = '0;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   out_q   = 1'b0;
    logic                   out_d;

    // The counter never goes past TERMINAL, so the +1 cannot wrap.
    always_comb begin
        count_d = count_q + COUNT_WIDTH'(1);
        out_d   = out_q;
        if (count_q == TERMINAL) begin
            count_d = '0;
            out_d   = ~out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            out_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_clk_divider.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_clk_divider
//   Three divider instances share one 12 MHz clock:
//     A: COUNT_WIDTH=4, MAX_COUNT=5   (divide by 12)
//     B: COUNT_WIDTH=1, MAX_COUNT=0   (divide by 2)
//     C: COUNT_WIDTH=4, MAX_COUNT=15  (full counter range, divide by 32)
//   Reference: n = rising edges since the last reset edge (or power-up),
//   expected out = floor(n / (MAX_COUNT+1)) mod 2.
// ---------------------------------------------------------------------------
module tb_clk_divider;

    localparam int MA = 5;
    localparam int MB = 0;
    localparam int MC = 15;

    logic clk   = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic rst_c = 1'b0;
    logic out_a;
    logic out_b;
    logic out_c;

    int checks   = 0;
    int failures = 0;

    // edges since last reset edge, per instance
    int n_a = 0;
    int n_b = 0;
    int n_c = 0;
    logic model_en = 1'b1;

    always #41.667 clk = ~clk;

    clk_divider #(.COUNT_WIDTH(4), .MAX_COUNT(MA)) u_a (.clk(clk), .rst(rst_a), .out(out_a));
    clk_divider #(.COUNT_WIDTH(1), .MAX_COUNT(MB)) u_b (.clk(clk), .rst(rst_b), .out(out_b));
    clk_divider #(.COUNT_WIDTH(4), .MAX_COUNT(MC)) u_c (.clk(clk), .rst(rst_c), .out(out_c));

    function automatic logic expect_out(input int n, input int m);
        return logic'((n / (m + 1)) % 2);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
        end
    endtask

    // Reference model: only what rst looks like at a rising edge matters.
    always @(posedge clk) begin
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
        n_c <= rst_c ? 0 : n_c + 1;
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (model_en) begin
            check("model_a", out_a, expect_out(n_a, MA));
            check("model_b", out_b, expect_out(n_b, MB));
            check("model_c", out_c, expect_out(n_c, MC));
        end
    end

    initial begin
        int waited;
        bit found;

        // Sub-cycle reset glitch before the first edge: must be invisible.
        #10;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Power-up run: literal pins on first rises and toggles.
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5)  check("a_edge5_low",   out_a, 1'b0);
            if (i == 6)  check("a_edge6_rise",  out_a, 1'b1);
            if (i == 11) check("a_edge11_high", out_a, 1'b1);
            if (i == 12) check("a_edge12_fall", out_a, 1'b0);
            if (i == 1)  check("b_edge1_rise",  out_b, 1'b1);
            if (i == 2)  check("b_edge2_fall",  out_b, 1'b0);
            if (i == 15) check("c_edge15_low",  out_c, 1'b0);
            if (i == 16) check("c_edge16_rise", out_c, 1'b1);
            if (i == 32) check("c_edge32_fall", out_c, 1'b0);
            if (i == 33) check("c_edge33_low",  out_c, 1'b0);
        end
        $display("phase power_up done checks=%0d", checks);

        // Mid-count reset on A while out=1 and count=3.
        found = 1'b0;
        waited = 0;
        while (!found && waited < 24) begin
            @(negedge clk);
            waited++;
            if (n_a % 12 == 9) found = 1'b1;
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL midcount_wait actual=timeout required=phase_found");
        end else begin
            check("a_pre_reset_high", out_a, 1'b1);
            rst_a = 1'b1;
            @(negedge clk);
            check("a_reset_edge_low", out_a, 1'b0);
            rst_a = 1'b0;
            repeat (5) @(negedge clk);
            check("a_post_reset5_low", out_a, 1'b0);
            @(negedge clk);
            check("a_post_reset6_rise", out_a, 1'b1);
        end
        $display("phase midcount_reset done checks=%0d", checks);

        // Reset held for 10 cycles on all instances.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_a_low", out_a, 1'b0);
            check("hold_b_low", out_b, 1'b0);
            check("hold_c_low", out_c, 1'b0);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 5)  check("rel_a_edge5_low",  out_a, 1'b0);
            if (i == 6)  check("rel_a_edge6_rise", out_a, 1'b1);
            if (i == 1)  check("rel_b_edge1_rise", out_b, 1'b1);
            if (i == 16) check("rel_c_edge16_rise", out_c, 1'b1);
        end
        $display("phase reset_hold done checks=%0d", checks);

        // Randomised sparse resets, independently per instance.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_a = ($urandom_range(0, 39) == 0);
            rst_b = ($urandom_range(0, 19) == 0);
            rst_c = ($urandom_range(0, 59) == 0);
        end
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (40) @(negedge clk);
        $display("phase random done checks=%0d", checks);

        model_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_divider.md
# clk_divider

- Module name: `clk_divider`.
- Divides the incoming system clock by an even ratio of 2·(MAX_COUNT+1) and produces a 50 % duty-cycle square wave on `out`.
- Used to derive slow clocks and blink rates from the 12 MHz board clock.
- `out` is a plain register output. Consumers sample it or edge-detect it as an enable; it is not routed onto a clock network inside this block.

## Interface
Parameters:
- `COUNT_WIDTH`, default 24: width in bits of the internal cycle counter.
- `MAX_COUNT`, default 5_999_999: terminal count. Half-period of `out` is MAX_COUNT+1 input cycles. The default gives 1 Hz from 12 MHz.

Ports:
- `clk`  input  1  system clock; all logic on its rising edge.
- `rst`  input  1  reset: one clock; reset is synchronous and active-high.
- `out`  output 1  divided square wave, registered.

## Operation
- State consists of the counter `count[COUNT_WIDTH-1:0]` (unsigned) and the output register `out`.
- Reset:
  - `rst` is sampled high on a rising edge of `clk`.
  - Result: `count <= 0`, `out <= 0`.
  - Reset has priority over counting.
  - Reset mid-period aborts the current half-period with no partial toggle.
- Power-up: both registers carry initial value 0. This lets the block run correctly in simulation and on FPGA without any reset pulse.
- Normal edge when `count == MAX_COUNT`: `count <= 0` and `out <= ~out`.
- Normal edge otherwise: `count <= count + 1`, and `out` holds.
- Counter range is 0..MAX_COUNT inclusive, so MAX_COUNT+1 states. It never reaches MAX_COUNT+1, and no modular wrap of COUNT_WIDTH occurs.
- Legality requirements:
  - 0 ≤ MAX_COUNT ≤ 2^COUNT_WIDTH − 1.
  - The design flags a violation at elaboration with a fatal error or assertion.
- MAX_COUNT = 0 is legal: `out` toggles every cycle, i.e. divide by 2.
- Comparison is an equality on the full COUNT_WIDTH bits; the constant is sized to COUNT_WIDTH.
- No other inputs exist; the block free-runs whenever `rst` is low.

## Timing
- Division ratio: f_out = f_clk / (2·(MAX_COUNT+1)).
- Duty cycle: exactly MAX_COUNT+1 cycles high and MAX_COUNT+1 cycles low.
- Latency after a reset edge E:
  - `out` = 0 from E onward.
  - First rise occurs at edge E+(MAX_COUNT+1).
  - Subsequent toggles occur every MAX_COUNT+1 edges.
- From power-up without reset: the first rise is at the (MAX_COUNT+1)th rising edge of `clk`.
- `out` changes only on rising edges of `clk`: glitch-free, with a single flop delay.
- Asynchronous `rst` pulses that contain no rising `clk` edge have no effect, by design (synchronous reset).
- Reset asserted on the same edge as a terminal count: reset wins, giving `out = 0` and `count = 0`.

## Test plan
- COUNT_WIDTH=4, MAX_COUNT=5, clk period 83.334 ns (12 MHz), 10 µs run:
  - `out` rises at the 6th rising edge (~458.3 ns).
  - `out` then toggles every 6 edges, giving a period of 12 clocks (~1000 ns, 1 MHz).
  - High time is 6 clocks and low time is 6 clocks.
- A 1 ns `rst` pulse between clock edges (t = 10–11 ns): no effect, and the waveform is identical to the no-reset case.
- Sync reset mid-count (MAX_COUNT=5):
  - Assert `rst` for one edge while `out` = 1 and count = 3: `out` = 0 and count = 0 on that edge.
  - Next rise occurs 6 edges later.
- Reset held for 10 cycles: `out` stays 0 and count stays 0 throughout. After release, the first rise comes 6 edges after the last reset edge.
- MAX_COUNT=0, COUNT_WIDTH=1: `out` toggles on every rising edge (f_clk/2), and the first rise is at edge 1.
- MAX_COUNT=15, COUNT_WIDTH=4 (full range): half-period is 16 cycles, with no overflow glitch; count goes 15 → 0 with a toggle.
